// File: rtl/cue_aim_ctrl.sv
// rtl/cue_aim_ctrl.sv - cue stick aim/charge/fire controller; optional CUE_POWER_PINGPONG_EN makes charge power bounce
module cue_aim_ctrl #(
  parameter int ANGLE_STEPS = 360,
  parameter int FRAC_BITS   = 9,
  parameter int BALL_SIZE   = 16,
  parameter int INIT_POWER  = 10,
  parameter int MAX_POWER   = 510,
  parameter int POWER_STEP  = 5,
  parameter int HOLD_FRAMES = 8,
  parameter int FAST_STEP   = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start_of_frame,
  input  logic                           up_pressed,
  input  logic                           down_pressed,
  input  logic                           space_pressed,
  input  logic                           game_state,
  input  logic                           no_moving_flag,
  input  logic [10:0]                    white_ball_x,
  input  logic [10:0]                    white_ball_y,
  output logic [10:0]                    stick_center_x,
  output logic [10:0]                    stick_center_y,
  output logic [$clog2(ANGLE_STEPS)-1:0] angle,
  output logic [9:0]                     power,
  output logic signed [31:0]             velocity_x,
  output logic signed [31:0]             velocity_y,
  output logic                           shot_valid,
  output logic signed [31:0]             shot_vx,
  output logic signed [31:0]             shot_vy,
  input  logic                           shot_ready,
  output logic [1:0]                     state
);

  localparam int AW      = $clog2(ANGLE_STEPS);
  localparam int QUARTER = ANGLE_STEPS / 4;
  localparam int IW      = $clog2(QUARTER + 1);
  localparam int HW      = $clog2(HOLD_FRAMES + 1);
  localparam int SCALE   = 1 << FRAC_BITS;

  typedef enum logic [1:0] {IDLE = 2'd0, AIM = 2'd1, CHARGE = 2'd2, FIRE = 2'd3} state_t;

  // sin over the first quadrant, scaled by 2^FRAC_BITS and rounded; evaluated at elaboration only
  function automatic logic [FRAC_BITS:0] quarter_sin(input int idx);
    real x, term, sum;
    x    = 1.5707963267948966 * $itor(idx) / $itor(QUARTER);
    term = x;
    sum  = x;
    for (int k = 1; k < 12; k++) begin
      term = -term * x * x / $itor((2 * k) * (2 * k + 1));
      sum  = sum + term;
    end
    return (FRAC_BITS + 1)'($rtoi(sum * $itor(SCALE) + 0.5));
  endfunction

  logic [FRAC_BITS:0] qtab [QUARTER + 1];

  for (genvar g = 0; g <= QUARTER; g++) begin : g_qtab
    localparam logic [FRAC_BITS:0] ENTRY = quarter_sin(g);
    assign qtab[g] = ENTRY;
  end

  state_t             state_q, state_d;
  logic [AW-1:0]      angle_q, angle_d;
  logic [9:0]         power_q, power_d;
  logic [HW-1:0]      hold_q, hold_d, eff_hold;
  logic [1:0]         dir_q, dir_d, dir_now;
  logic               shot_valid_q, shot_valid_d;
  logic signed [31:0] shot_vx_q, shot_vx_d, shot_vy_q, shot_vy_d;
  logic [10:0]        cx_q, cy_q;
  logic [9:0]         charge_pw;
  logic [10:0]        pw_up;
  int                 step, a_rot, a;
  logic [AW-1:0]      rot_angle;
  logic [HW-1:0]      rot_hold;
  logic [IW-1:0]      sin_idx, cos_idx;
  logic               sin_neg, cos_neg;
  logic signed [31:0] sin_s, cos_s, pow_s;

`ifdef CUE_POWER_PINGPONG_EN
  logic falling_q, charge_fall;
`endif

  // ball centre follows the sprite position one cycle later
  always_ff @(posedge clk) begin
    if (reset) begin
      cx_q <= 11'(BALL_SIZE / 2);
      cy_q <= 11'(BALL_SIZE / 2);
    end else begin
      cx_q <= white_ball_x + 11'(BALL_SIZE / 2);
      cy_q <= white_ball_y + 11'(BALL_SIZE / 2);
    end
  end

  // rotation: slow for the first HOLD_FRAMES frames of a steady press, then fast; wraps both ways
  always_comb begin
    dir_now   = {down_pressed & ~up_pressed, up_pressed & ~down_pressed};
    eff_hold  = (dir_now == dir_q) ? hold_q : '0;
    step      = (eff_hold >= HW'(HOLD_FRAMES)) ? FAST_STEP : 1;
    a_rot     = int'(angle_q);
    rot_hold  = '0;
    if (dir_now == 2'b01) begin
      a_rot = a_rot + step;
      if (a_rot >= ANGLE_STEPS) a_rot = a_rot - ANGLE_STEPS;
    end else if (dir_now == 2'b10) begin
      a_rot = a_rot - step;
      if (a_rot < 0) a_rot = a_rot + ANGLE_STEPS;
    end
    if (dir_now != 2'b00) begin
      rot_hold = (eff_hold >= HW'(HOLD_FRAMES)) ? HW'(HOLD_FRAMES) : eff_hold + HW'(1);
    end
    rot_angle = AW'(a_rot);
  end

  // power value for the next charging frame
  always_comb begin
    charge_pw = power_q;
    pw_up     = {1'b0, power_q} + 11'(POWER_STEP);
`ifdef CUE_POWER_PINGPONG_EN
    charge_fall = falling_q;
    if (!falling_q) begin
      if (pw_up >= 11'(MAX_POWER)) begin
        charge_pw   = 10'(MAX_POWER);
        charge_fall = 1'b1;
      end else begin
        charge_pw = pw_up[9:0];
      end
    end else if ({1'b0, power_q} <= 11'(INIT_POWER + POWER_STEP)) begin
      charge_pw   = 10'(INIT_POWER);
      charge_fall = 1'b0;
    end else begin
      charge_pw = power_q - 10'(POWER_STEP);
    end
`else
    charge_pw = (pw_up >= 11'(MAX_POWER)) ? 10'(MAX_POWER) : pw_up[9:0];
`endif
  end

`ifdef CUE_POWER_PINGPONG_EN
  // bounce direction lives only while charging; cleared whenever charge ends
  always_ff @(posedge clk) begin
    if (reset || state_d != CHARGE) falling_q <= 1'b0;
    else if (start_of_frame)        falling_q <= charge_fall;
  end
`endif

  // live preview vector from the quarter-wave table folded into four quadrants
  always_comb begin
    sin_neg = 1'b0;
    cos_neg = 1'b0;
    a       = int'(angle_q);
    if (a < QUARTER) begin
      sin_idx = IW'(a);
      cos_idx = IW'(QUARTER - a);
    end else if (a < 2 * QUARTER) begin
      sin_idx = IW'(2 * QUARTER - a);
      cos_idx = IW'(a - QUARTER);
      cos_neg = 1'b1;
    end else if (a < 3 * QUARTER) begin
      sin_idx = IW'(a - 2 * QUARTER);
      cos_idx = IW'(3 * QUARTER - a);
      sin_neg = 1'b1;
      cos_neg = 1'b1;
    end else begin
      sin_idx = IW'(ANGLE_STEPS - a);
      cos_idx = IW'(a - 3 * QUARTER);
      sin_neg = 1'b1;
    end
    sin_s      = sin_neg ? -$signed(32'(qtab[sin_idx])) : $signed(32'(qtab[sin_idx]));
    cos_s      = cos_neg ? -$signed(32'(qtab[cos_idx])) : $signed(32'(qtab[cos_idx]));
    pow_s      = $signed(32'(power_q));
    velocity_x = (pow_s * cos_s) / SCALE;
    velocity_y = (pow_s * sin_s) / SCALE;
  end

  // next state: game stop beats the handshake, which beats frame-paced updates
  always_comb begin
    state_d      = state_q;
    angle_d      = angle_q;
    power_d      = power_q;
    hold_d       = hold_q;
    dir_d        = dir_q;
    shot_valid_d = shot_valid_q;
    shot_vx_d    = shot_vx_q;
    shot_vy_d    = shot_vy_q;
    if (!game_state) begin
      state_d      = IDLE;
      power_d      = 10'(INIT_POWER);
      shot_valid_d = 1'b0;
      hold_d       = '0;
      dir_d        = 2'b00;
    end else if (state_q == FIRE) begin
      if (shot_valid_q && shot_ready) begin
        state_d      = IDLE;
        shot_valid_d = 1'b0;
        power_d      = 10'(INIT_POWER);
      end
    end else if (start_of_frame) begin
      case (state_q)
        IDLE: if (no_moving_flag) state_d = AIM;
        AIM: begin
          if (space_pressed) begin
            state_d = CHARGE;
            power_d = charge_pw;
            hold_d  = '0;
            dir_d   = 2'b00;
          end else begin
            angle_d = rot_angle;
            hold_d  = rot_hold;
            dir_d   = dir_now;
          end
        end
        CHARGE: begin
          if (space_pressed) begin
            power_d = charge_pw;
          end else begin
            state_d      = FIRE;
            shot_valid_d = 1'b1;
            shot_vx_d    = velocity_x;
            shot_vy_d    = velocity_y;
          end
        end
        default: ;
      endcase
    end
  end

  // FSM and aim/shot registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      angle_q      <= '0;
      power_q      <= 10'(INIT_POWER);
      hold_q       <= '0;
      dir_q        <= 2'b00;
      shot_valid_q <= 1'b0;
      shot_vx_q    <= '0;
      shot_vy_q    <= '0;
    end else begin
      state_q      <= state_d;
      angle_q      <= angle_d;
      power_q      <= power_d;
      hold_q       <= hold_d;
      dir_q        <= dir_d;
      shot_valid_q <= shot_valid_d;
      shot_vx_q    <= shot_vx_d;
      shot_vy_q    <= shot_vy_d;
    end
  end

  assign stick_center_x = cx_q;
  assign stick_center_y = cy_q;
  assign angle          = angle_q;
  assign power          = power_q;
  assign shot_valid     = shot_valid_q;
  assign shot_vx        = shot_vx_q;
  assign shot_vy        = shot_vy_q;
  assign state          = state_q;

endmodule

// File: tb/tb_cue_aim_ctrl.sv
// tb/tb_cue_aim_ctrl.sv - directed vector bench for cue_aim_ctrl
module tb_cue_aim_ctrl;

  logic               clk = 1'b0;
  logic               reset, sof, up, dn, sp, gm, nm, shot_ready;
  logic [10:0]        wbx, wby, scx, scy;
  logic [8:0]         angle;
  logic [9:0]         power;
  logic signed [31:0] vx, vy, svx, svy;
  logic               shot_valid;
  logic [1:0]         state;

  int n_checks = 0;
  int n_errors = 0;

`ifdef CUE_POWER_PINGPONG_EN
  localparam int EXP_P101 = 505;
  localparam int EXP_P120 = 410;
`else
  localparam int EXP_P101 = 510;
  localparam int EXP_P120 = 510;
`endif

  typedef struct {
    logic u, d, s, g, m;
    int   st, ang, pw;
    logic cv;
    int   evx, evy;
  } vec_t;

  vec_t vecs [15];

  cue_aim_ctrl dut (
    .clk(clk), .reset(reset), .start_of_frame(sof),
    .up_pressed(up), .down_pressed(dn), .space_pressed(sp),
    .game_state(gm), .no_moving_flag(nm),
    .white_ball_x(wbx), .white_ball_y(wby),
    .stick_center_x(scx), .stick_center_y(scy),
    .angle(angle), .power(power),
    .velocity_x(vx), .velocity_y(vy),
    .shot_valid(shot_valid), .shot_vx(svx), .shot_vy(svy),
    .shot_ready(shot_ready), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic u, input logic d, input logic s, input logic g, input logic m);
    up = u; dn = d; sp = s; gm = g; nm = m; sof = 1'b1;
    @(posedge clk);
    #1 sof = 1'b0;
  endtask

  function automatic vec_t mk(input logic u, input logic d, input logic s, input int st, input int ang,
                              input logic cv, input int evx, input int evy);
    vec_t v;
    v.u = u; v.d = d; v.s = s; v.g = 1'b1; v.m = 1'b1;
    v.st = st; v.ang = ang; v.pw = 10; v.cv = cv; v.evx = evx; v.evy = evy;
    return v;
  endfunction

  initial begin
    vecs[0]  = mk(0, 0, 0, 1, 0,   1, 10, 0);
    vecs[1]  = mk(0, 1, 0, 1, 359, 1, 10, 0);
    vecs[2]  = mk(1, 0, 0, 1, 0,   1, 10, 0);
    for (int i = 3; i <= 9; i++) vecs[i] = mk(1, 0, 0, 1, i - 2, 0, 0, 0);
    vecs[10] = mk(1, 0, 0, 1, 11, 0, 0, 0);
    vecs[11] = mk(1, 0, 0, 1, 15, 0, 0, 0);
    vecs[12] = mk(0, 0, 0, 1, 15, 0, 0, 0);
    vecs[13] = mk(1, 1, 0, 1, 15, 0, 0, 0);
    vecs[14] = mk(0, 1, 0, 1, 14, 0, 0, 0);

    reset = 1'b1; sof = 1'b0; up = 1'b0; dn = 1'b0; sp = 1'b0; gm = 1'b0; nm = 1'b0;
    shot_ready = 1'b0; wbx = 11'd100; wby = 11'd200;
    tick();
    tick();
    check("rst_state", state, 0);
    check("rst_angle", angle, 0);
    check("rst_power", power, 10);
    check("rst_valid", shot_valid, 0);
    check("rst_svx", svx, 0);
    check("rst_svy", svy, 0);
    check("rst_cx", scx, 8);
    check("rst_cy", scy, 8);

    reset = 1'b0;
    gm = 1'b1; nm = 1'b1;
    tick();
    check("center_x", scx, 108);
    check("center_y", scy, 208);
    check("no_frame_idle", state, 0);

    for (int i = 0; i < 15; i++) begin
      frame(vecs[i].u, vecs[i].d, vecs[i].s, vecs[i].g, vecs[i].m);
      check($sformatf("vec%0d_state", i), state, vecs[i].st);
      check($sformatf("vec%0d_angle", i), angle, vecs[i].ang);
      check($sformatf("vec%0d_power", i), power, vecs[i].pw);
      if (vecs[i].cv) begin
        check($sformatf("vec%0d_vx", i), vx, vecs[i].evx);
        check($sformatf("vec%0d_vy", i), vy, vecs[i].evy);
      end
    end

    for (int i = 0; i < 25; i++) frame(1, 0, 0, 1, 1);
    frame(0, 0, 0, 1, 1);
    check("aim90_angle", angle, 90);
    check("aim90_vx", vx, 0);
    check("aim90_vy", vy, 10);

    frame(0, 0, 1, 1, 1);
    check("charge_state", state, 2);
    check("charge_first_power", power, 15);
    for (int i = 1; i < 100; i++) frame(0, 0, 1, 1, 1);
    check("charge_f100_power", power, 510);
    frame(0, 0, 1, 1, 1);
    check("charge_f101_power", power, EXP_P101);
    for (int i = 101; i < 120; i++) frame(0, 0, 1, 1, 1);
    check("charge_f120_power", power, EXP_P120);
    check("charge_angle_frozen", angle, 90);
    check("charge_no_valid", shot_valid, 0);

    frame(0, 0, 0, 1, 1);
    check("fire_state", state, 3);
    check("fire_valid", shot_valid, 1);
    check("fire_svx", svx, 0);
    check("fire_svy", svy, EXP_P120);

    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("hold%0d_valid", i), shot_valid, 1);
      check($sformatf("hold%0d_svy", i), svy, EXP_P120);
      check($sformatf("hold%0d_svx", i), svx, 0);
    end
    shot_ready = 1'b1;
    tick();
    shot_ready = 1'b0;
    check("hs_valid", shot_valid, 0);
    check("hs_power", power, 10);
    check("hs_state", state, 0);
    check("hs_angle_kept", angle, 90);

    frame(0, 0, 0, 1, 0);
    check("moving_stay_idle", state, 0);
    frame(0, 0, 0, 1, 1);
    check("rearm_state", state, 1);
    check("rearm_angle", angle, 90);

    frame(0, 0, 1, 1, 1);
    frame(0, 0, 1, 1, 1);
    check("c2_power", power, 20);
    gm = 1'b0;
    tick();
    check("drop_state", state, 0);
    check("drop_power", power, 10);
    check("drop_valid", shot_valid, 0);
    frame(0, 0, 1, 0, 1);
    check("drop_stay_idle", state, 0);
    check("drop_still_no_valid", shot_valid, 0);

    frame(0, 0, 0, 1, 1);
    frame(0, 0, 1, 1, 1);
    frame(0, 0, 0, 1, 1);
    check("fire2_valid", shot_valid, 1);
    check("fire2_svy", svy, 15);
    reset = 1'b1;
    shot_ready = 1'b1;
    tick();
    reset = 1'b0;
    shot_ready = 1'b0;
    check("rst_fire_state", state, 0);
    check("rst_fire_valid", shot_valid, 0);
    check("rst_fire_svy", svy, 0);
    check("rst_fire_angle", angle, 0);
    check("rst_fire_power", power, 10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cue_aim_ctrl.md
CUE_AIM_CTRL -- requirements
Module: cue_aim_ctrl

Interface
REQ-001 SHALL have parameter ANGLE_STEPS, default 360: angle resolution per full turn; must be a multiple of 4.
REQ-002 SHALL have parameter FRAC_BITS, default 9: trig scale, where 1.0 = 2^FRAC_BITS.
REQ-003 SHALL have parameter BALL_SIZE, default 16: ball sprite edge in pixels.
REQ-004 SHALL have parameter INIT_POWER, default 10: power value after reset and on every re-arm.
REQ-005 SHALL have parameter MAX_POWER, default 510: power ceiling.
REQ-006 SHALL have parameter POWER_STEP, default 5: power increment per frame.
REQ-007 SHALL have parameter HOLD_FRAMES, default 8: frames of continuous rotate press before fast rotation starts.
REQ-008 SHALL have parameter FAST_STEP, default 4: angle step per frame in fast rotation.
REQ-009 SHALL have the following ports (clock and reset first):
- clk  in  1  single system clock.
- reset  in  1  synchronous, active-high.
- start_of_frame  in  1  one-cycle frame tick.
- up_pressed, down_pressed, space_pressed  in  1 each  key levels.
- game_state  in  1  1 = game running.
- no_moving_flag  in  1  1 = all balls at rest.
- white_ball_x, white_ball_y  in  11 each  ball top-left position.
- stick_center_x, stick_center_y  out  11 each  registered ball centre.
- angle  out  $clog2(ANGLE_STEPS)  current aim.
- power  out  10  current power.
- velocity_x, velocity_y  out  32 signed  live preview vector.
- shot_valid  out  1  latched shot is available.
- shot_vx, shot_vy  out  32 signed  latched shot vector.
- shot_ready  in  1  consumer accepts the shot.
- state  out  2  FSM state.

Function
REQ-010 SHALL update stick_center = white_ball + BALL_SIZE/2 every clk, with 1-cycle latency.
REQ-011 SHALL implement FSM states IDLE=0, AIM=1, CHARGE=2, FIRE=3; except for the handshake, all updates SHALL occur only on cycles where start_of_frame=1.
REQ-012 SHALL force IDLE whenever game_state=0, from any state, on the next clk; this forces shot_valid=0 and power=INIT_POWER.
REQ-013 SHALL move IDLE->AIM on a frame where game_state=1 and no_moving_flag=1; angle is retained, not zeroed.
REQ-014 In AIM, SHALL step angle per frame: up = +step, down = -step, both or neither = hold; angle wraps modulo ANGLE_STEPS in both directions.
REQ-015 SHALL set step=1 for the first HOLD_FRAMES frames of an unbroken press and step=FAST_STEP thereafter; the hold counter clears on release and on direction change, and saturates.
REQ-016 SHALL move AIM->CHARGE on a frame where space_pressed=1; in CHARGE, angle is frozen and power += POWER_STEP each frame, saturating at MAX_POWER.
REQ-017 SHALL move CHARGE->FIRE on the first frame with space_pressed=0; on that clk it latches shot_vx/shot_vy from the current preview values and asserts shot_valid.
REQ-018 SHALL hold shot_valid, shot_vx and shot_vy stable until a clk with shot_valid=1 and shot_ready=1 (this clk need not be a frame tick); the next clk then deasserts shot_valid, resets power to INIT_POWER and enters IDLE.
REQ-019 SHALL compute velocity_x = (power*cos(angle)) / 2^FRAC_BITS and velocity_y = (power*sin(angle)) / 2^FRAC_BITS combinationally, using signed division truncating toward zero.
REQ-020 SHALL derive sin/cos from an internal quarter-wave table of ANGLE_STEPS/4+1 entries, rounded to nearest; cos(0)=2^FRAC_BITS, sin(ANGLE_STEPS/4)=2^FRAC_BITS.
REQ-021 SHALL return IDLE->AIM only after no_moving_flag=1 on a frame, so no re-arm occurs while balls are moving.

Reset
REQ-022 On reset=1 at posedge clk, SHALL set: state=IDLE, angle=0, power=INIT_POWER, hold counter=0, shot_valid=0, shot_vx=shot_vy=0, stick_center=(BALL_SIZE/2, BALL_SIZE/2).
REQ-023 Reset SHALL take priority over start_of_frame and over the shot handshake, including while in FIRE.

Configuration
REQ-024 With CUE_POWER_PINGPONG_EN defined, SHALL make CHARGE power bounce: it rises to MAX_POWER, then falls by POWER_STEP to INIT_POWER, then rises again, clamping at both ends.
REQ-025 Without CUE_POWER_PINGPONG_EN, SHALL saturate power at MAX_POWER per REQ-016, and no direction register is synthesised.

Verification
REQ-026 Bench SHALL check: reset, game_state=1, no_moving_flag=1, 1 frame -> state=AIM, angle=0, velocity_x=10, velocity_y=0.
REQ-027 Bench SHALL check: down_pressed for 1 frame at angle 0 -> angle=359; then up_pressed for 10 frames -> angle sequence 0..7, then 11, 15.
REQ-028 Bench SHALL check: space held 120 frames from power 10 -> power=510 (saturated); release with angle=90 -> shot_vx=0, shot_vy=510, shot_valid=1.
REQ-029 Bench SHALL check: shot_ready held low 5 cycles -> shot_valid and shot vector stable; shot_ready=1 for 1 cycle -> shot_valid=0 next clk, power=10, state=IDLE.
REQ-030 Bench SHALL check: game_state dropped while in CHARGE -> state=IDLE and power=10 next clk, with no shot_valid pulse.
REQ-031 Bench SHALL check: with CUE_POWER_PINGPONG_EN defined, space held 101 frames -> power=505 (after peaking at 510).
